lm_event_queue: RTL and testbench
=================================

# lm_event_queue

LED-manager event queue: buffers LED patterns posted by the error/status producers and presents them one at a time to the LED-manager decoder. Each queued pattern is shown for a fixed dwell time before the next is popped, so short bursts of events remain visible on the board. Outputs `rd_data`/`fifo_empty` connect directly to the decoder's inputs of the same name; the decoder has no read strobe, so this block owns all popping.

## Interface
- `WIDTH`, default `WIDTH_LEDS` (from `LM_params.v`): LED pattern width.
- `DEPTH`, default 8: queue entries; power of two, ≥2.
- `HOLD_CYCLES`, default 25_000_000: dwell cycles per entry; ≥1.
- `LAST_STICKY`, default 1: 1 = final entry is held until a newer one arrives; 0 = it is popped after its dwell like any other.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: push `wr_data` this cycle.
- `wr_data` input WIDTH: LED pattern to queue.
- `flush` input 1: synchronous clear of all entries.
- `rd_data` output WIDTH: head entry; 0 when empty.
- `fifo_empty` output 1: no entry to display.
- `full` output 1: count == DEPTH.
- `overflow` output 1: one-cycle registered pulse, push dropped because full.
- `count` output $clog2(DEPTH)+1: entries held.

## Operation
- Storage: DEPTH×WIDTH register array with `wr_ptr`/`rd_ptr` ($clog2(DEPTH) bits, natural wrap) and registered `count`.
- Push is accepted when `wr_en && !full` (using the registered `full`). A push while full is dropped; `overflow` goes high for the next cycle only. A pop in the same cycle does not free a slot for the push.
- `rd_data` = `mem[rd_ptr]` when `count != 0`, else 0. `fifo_empty` = (`count == 0`). `full` = (`count == DEPTH`).
- Dwell FSM, with a `dwell_cnt` counter of $clog2(HOLD_CYCLES)+1 bits:
  - EMPTY: `count == 0`; `dwell_cnt` = 0. An accepted push moves the FSM to SHOW.
  - SHOW: `dwell_cnt` increments each cycle. When `dwell_cnt == HOLD_CYCLES-1`, the FSM pops: `rd_ptr`+1, `count`-1 (+1 if a push is also accepted), `dwell_cnt` ← 0.
    - If count after the pop is 0, go to EMPTY.
    - If `LAST_STICKY=1` and `count == 1` with no push accepted at expiry, do not pop; go to HOLD_LAST.
  - HOLD_LAST: `dwell_cnt` frozen. An accepted push pops the old head at that same edge (count stays 1), `dwell_cnt` ← 0, and the FSM goes to SHOW.
- Push and pop in the same cycle: `count` unchanged and both pointers advance.
- `flush`: pointers, `count` and `dwell_cnt` ← 0; FSM ← EMPTY. `flush` has priority over a simultaneous push, which is discarded without raising `overflow`.
- Array contents are not reset; visibility is gated by `count`.

## Timing
- Reset values: `rd_data`=0, `fifo_empty`=1, `full`=0, `overflow`=0, `count`=0, FSM=EMPTY, pointers=0.
- A push accepted in cycle t: `fifo_empty`=0 and `rd_data` valid from t+1. The decoder registers the value, so it reaches the LEDs at t+2.
- Each head is presented for exactly HOLD_CYCLES cycles, counted from the first cycle it is visible, before being replaced or cleared. A sticky head is presented until the cycle after the push that displaces it.
- `overflow` goes high in cycle t+1 for a dropped push in cycle t.
- A `rst` assertion at any time clears the queue immediately and returns every output to its reset value. Operation resumes on the first edge after deassertion.

## Test plan
- WIDTH=8, DEPTH=4, HOLD=4, STICKY=0; push 0xA5 at cycle 0 → `fifo_empty` low and `rd_data`=0xA5 in cycles 1–4; empty with `rd_data`=0 from cycle 5.
- Same config; push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles → `full`=1 after the 4th; 5th dropped with `overflow` pulse; display sequence 0x01..0x04, 4 cycles each; 0x05 never appears.
- STICKY=1; push 0x3C, wait 20 cycles → 0x3C is still shown and `count`=1. Push 0x0F → 0x0F is shown on the next cycle, `count`=1, then 0x0F holds.
- DEPTH=4 with 2 entries; push coincides with dwell expiry → `count` stays 2; pointers advance and wrap correctly across 3 full laps.
- 3 entries queued; `flush` together with `wr_en` (data 0xFF) → next cycle `count`=0, `fifo_empty`=1, no `overflow`, 0xFF never shown.
- `rst` pulsed mid-dwell with 3 entries → all outputs at reset values immediately; after release, pushing 0x11 gives a fresh full HOLD-cycle dwell.

Source files
------------

// File: rtl/lm_event_queue.sv
// lm_event_queue
//   Queues LED patterns posted by the error/status producers and shows them
//   to the LED-manager decoder one at a time. Each head stays visible for
//   HOLD_CYCLES cycles before it is popped. With LAST_STICKY=1 the final
//   entry stays on display until a newer pattern displaces it. The decoder
//   has no read strobe, so every pop is decided here.
//
// Parameters
//   WIDTH        LED pattern width. Set it to WIDTH_LEDS from LM_params.v
//                at instantiation.
//   DEPTH        number of queue entries (power of two, >= 2)
//   HOLD_CYCLES  dwell cycles per entry (>= 1)
//   LAST_STICKY  1: hold the last entry until a newer one arrives
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   wr_en       push wr_data this cycle
//   wr_data     LED pattern to queue
//   flush       synchronous clear of all entries; wins over a push
//   rd_data     head entry, 0 when empty
//   fifo_empty  no entry to display
//   full        count == DEPTH
//   overflow    one-cycle registered pulse: a push was dropped because full
//   count       number of entries held
module lm_event_queue #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int LAST_STICKY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       fifo_empty,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_SHOW,
    S_HOLD_LAST
  } state_t;

  state_t            state, state_next;
  logic [DW-1:0]     dwell_cnt, dwell_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              push_ok;
  logic              pop;
  logic              dwell_done;

  // full comes from the registered count, so a pop in the same cycle never
  // makes room for a push. A flush swallows any simultaneous push.
  assign full       = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push_ok    = wr_en && !full && !flush;
  assign dwell_done = (dwell_cnt == DW'(HOLD_CYCLES - 1));
  assign rd_data    = fifo_empty ? '0 : mem[rd_ptr];

  // Dwell FSM: next state, pop request and next dwell count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_next = state;
    dwell_next = dwell_cnt;
    pop        = 1'b0;

    unique case (state)
      S_EMPTY: begin
        dwell_next = '0;
        if (push_ok) state_next = S_SHOW;
      end

      S_SHOW: begin
        if (!dwell_done) begin
          dwell_next = dwell_cnt + DW'(1);
        end else if (LAST_STICKY != 0 && count == CW'(1) && !push_ok) begin
          // Last entry in sticky mode: keep it and freeze the counter.
          state_next = S_HOLD_LAST;
        end else begin
          pop        = 1'b1;
          dwell_next = '0;
          if (count == CW'(1) && !push_ok) state_next = S_EMPTY;
        end
      end

      S_HOLD_LAST: begin
        // A new pattern displaces the sticky head at the same edge.
        if (push_ok) begin
          pop        = 1'b1;
          dwell_next = '0;
          state_next = S_SHOW;
        end
      end

      default: begin
        state_next = S_EMPTY;
        dwell_next = '0;
      end
    endcase

    if (flush) begin
      state_next = S_EMPTY;
      dwell_next = '0;
      pop        = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      dwell_cnt <= '0;
    end else begin
      state     <= state_next;
      dwell_cnt <= dwell_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. count decides which slots are
  // visible, so stale contents never reach rd_data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_lm_event_queue.sv
// Directed testbench for lm_event_queue.
//   u_dut0: WIDTH=8, DEPTH=4, HOLD_CYCLES=4, LAST_STICKY=0
//   u_dut1: WIDTH=8, DEPTH=4, HOLD_CYCLES=4, LAST_STICKY=1
// Inputs change #1 after a rising edge, and outputs are sampled there.
// "Cycle c" is the interval that follows rising edge c.
module tb_lm_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en0, flush0, wr_en1, flush1;
  logic [7:0] wr_data0, wr_data1;
  logic [7:0] rd_data0, rd_data1;
  logic       empty0, empty1, full0, full1, ovf0, ovf1;
  logic [2:0] count0, count1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lm_event_queue #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(4), .LAST_STICKY(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .flush(flush0),
    .rd_data(rd_data0), .fifo_empty(empty0), .full(full0), .overflow(ovf0),
    .count(count0)
  );

  lm_event_queue #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(4), .LAST_STICKY(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .flush(flush1),
    .rd_data(rd_data1), .fifo_empty(empty1), .full(full1), .overflow(ovf1),
    .count(count1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] d [14];

    rst = 1'b1;
    wr_en0 = 1'b0; wr_data0 = '0; flush0 = 1'b0;
    wr_en1 = 1'b0; wr_data1 = '0; flush1 = 1'b0;
    #12;
    check("rst_rd_data", rd_data0, 0);
    check("rst_empty",   empty0,   1);
    check("rst_full",    full0,    0);
    check("rst_ovf",     ovf0,     0);
    check("rst_count",   count0,   0);
    step();
    rst = 1'b0;

    // Single push: visible in cycles 1..4, empty from cycle 5.
    wr_en0 = 1'b1; wr_data0 = 8'hA5;
    step();
    wr_en0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("single_rd_c%0d", c), rd_data0, 8'hA5);
      check($sformatf("single_empty_c%0d", c), empty0, 0);
      step();
    end
    check("single_after_rd", rd_data0, 0);
    check("single_after_empty", empty0, 1);

    // Burst of five: the fifth is dropped while full.
    wr_en0 = 1'b1; wr_data0 = 8'h01;
    step();
    for (int c = 1; c <= 17; c++) begin
      check($sformatf("burst_rd_c%0d", c), rd_data0,
            (c <= 16) ? ((c - 1) / 4 + 1) : 0);
      if (c == 4) begin
        check("burst_full", full0, 1);
        check("burst_count_full", count0, 4);
      end
      if (c == 5) begin
        check("burst_ovf_pulse", ovf0, 1);
        check("burst_count_after_drop", count0, 3);
      end
      if (c == 6) check("burst_ovf_cleared", ovf0, 0);
      if (c <= 4) begin
        wr_en0 = 1'b1; wr_data0 = 8'(c + 1);
      end else begin
        wr_en0 = 1'b0;
      end
      step();
    end
    check("burst_drained_empty", empty0, 1);

    // Sticky last entry.
    wr_en1 = 1'b1; wr_data1 = 8'h3C;
    step();
    wr_en1 = 1'b0;
    repeat (20) step();
    check("sticky_rd", rd_data1, 8'h3C);
    check("sticky_count", count1, 1);
    wr_en1 = 1'b1; wr_data1 = 8'h0F;
    step();
    wr_en1 = 1'b0;
    check("sticky_replace_rd", rd_data1, 8'h0F);
    check("sticky_replace_count", count1, 1);
    repeat (10) step();
    check("sticky_hold_rd", rd_data1, 8'h0F);
    check("sticky_hold_count", count1, 1);
    check("sticky_hold_empty", empty1, 0);

    // Push on every dwell expiry with two entries held: three pointer laps.
    for (int i = 0; i < 14; i++) d[i] = 8'h10 + 8'(i);
    wr_en0 = 1'b1; wr_data0 = d[0];
    step();
    wr_data0 = d[1];
    step();
    wr_en0 = 1'b0;
    step();
    step();
    for (int n = 0; n < 12; n++) begin
      check($sformatf("wrap_head_n%0d", n), rd_data0, d[n]);
      check($sformatf("wrap_count_pre_n%0d", n), count0, 2);
      wr_en0 = 1'b1; wr_data0 = d[n + 2];
      step();
      wr_en0 = 1'b0;
      check($sformatf("wrap_count_post_n%0d", n), count0, 2);
      check($sformatf("wrap_next_n%0d", n), rd_data0, d[n + 1]);
      repeat (3) step();
    end

    // Reach three entries, then flush together with a push of 0xFF.
    wr_en0 = 1'b1; wr_data0 = 8'h77;
    step();
    wr_data0 = 8'h78;
    step();
    wr_en0 = 1'b0;
    check("flush_pre_count", count0, 3);
    wr_en0 = 1'b1; wr_data0 = 8'hFF; flush0 = 1'b1;
    step();
    wr_en0 = 1'b0; flush0 = 1'b0;
    check("flush_count", count0, 0);
    check("flush_empty", empty0, 1);
    check("flush_no_ovf", ovf0, 0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("flush_rd_c%0d", c), rd_data0, 0);
      step();
    end

    // Reset in mid-dwell with three entries queued.
    wr_en0 = 1'b1; wr_data0 = 8'h21;
    step();
    wr_data0 = 8'h22;
    step();
    wr_data0 = 8'h23;
    step();
    wr_en0 = 1'b0;
    check("prerst_count", count0, 3);
    rst = 1'b1;
    #1;
    check("async_rst_rd", rd_data0, 0);
    check("async_rst_empty", empty0, 1);
    check("async_rst_full", full0, 0);
    check("async_rst_ovf", ovf0, 0);
    check("async_rst_count", count0, 0);
    step();
    rst = 1'b0;
    wr_en0 = 1'b1; wr_data0 = 8'h11;
    step();
    wr_en0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("postrst_rd_c%0d", c), rd_data0, 8'h11);
      step();
    end
    check("postrst_empty", empty0, 1);
    check("postrst_rd_zero", rd_data0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
